dram_arbiter: RTL

- Shares the single-port data DRAM (14-bit address, async read `spo`, sync write on `we`) between two requesters.
  - CPU data port: load/store accesses.
  - DMA/loader port: burst fills and dumps of data memory.
- Registered-state arbiter, round-robin between the two requesters.
- DMA bursts are bounded so the CPU cannot starve.
- Sits between `myCPU`'s DRAM interface and the DRAM instance inside the SoC top.

---
 rtl/dram_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/dram_arbiter.sv
// Shares one single-port DRAM between a CPU port and a bursting DMA port, round-robin with bounded DMA bursts.
// Grant one cycle after a request from idle; acks are combinational from state; requesters hold until acked.
module dram_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_last,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_spo,
  output logic              dma_owner
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_DMA} state_t;

  state_t             state_q, state_d;
  logic               rr_pref_q, rr_pref_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]   beat_nxt;

  // rr_pref: 0 favours the CPU on contention, 1 favours the DMA.
  function automatic state_t arb(input logic c_req, input logic d_req, input logic pref);
    if (c_req && d_req) return pref ? S_DMA : S_CPU;
    if (c_req)          return S_CPU;
    if (d_req)          return S_DMA;
    return S_IDLE;
  endfunction

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q    <= S_IDLE;
      rr_pref_q  <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_pref_q  <= rr_pref_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_pref_d  = rr_pref_q;
    beat_cnt_d = beat_cnt_q;
    beat_nxt   = beat_cnt_q + 1'b1;
    case (state_q)
      S_IDLE: state_d = arb(cpu_req, dma_req, rr_pref_q);
      S_CPU: begin
        state_d   = arb(cpu_req, dma_req, 1'b1);
        rr_pref_d = 1'b1;
      end
      S_DMA: begin
        if (dma_req) begin
          beat_cnt_d = beat_nxt;
          if (dma_last) begin
            state_d    = cpu_req ? S_CPU : S_IDLE;
            rr_pref_d  = 1'b0;
            beat_cnt_d = '0;
          end else if (beat_nxt == CNT_W'(MAX_BURST)) begin
            // Burst budget spent: yield only if the CPU is actually waiting.
            beat_cnt_d = '0;
            if (cpu_req) begin
              state_d   = S_CPU;
              rr_pref_d = 1'b0;
            end
          end
        end else begin
          state_d    = cpu_req ? S_CPU : S_IDLE;
          rr_pref_d  = 1'b0;
          beat_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DMA && state_q != S_DMA) beat_cnt_d = '0;
  end

  always_comb begin
    mem_a   = cpu_addr;
    mem_d   = cpu_wdata;
    mem_we  = 1'b0;
    cpu_ack = 1'b0;
    dma_ack = 1'b0;
    case (state_q)
      S_CPU: begin
        mem_we  = cpu_we;
        cpu_ack = 1'b1;
      end
      S_DMA: begin
        mem_a   = dma_addr;
        mem_d   = dma_wdata;
        mem_we  = dma_we & dma_req;
        dma_ack = dma_req;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = mem_spo;
  assign dma_rdata = mem_spo;
  assign dma_owner = (state_q == S_DMA);

endmodule
